// File: rtl/dsram_pkg.sv
// Shared constants for the data-side SRAM responder: request size codes,
// response-pipeline bounds and the stall LFSR definition.
package dsram_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int MAX_LATENCY = 7;
  // Outstanding count ranges 0..MAX_LATENCY+1.
  localparam int CNT_W = $clog2(MAX_LATENCY + 2);

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting form of taps 16,14,13,11: feedback = b0 ^ b2 ^ b3 ^ b5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

endpackage

// File: rtl/dsram_resp_pipe.sv
// LATENCY-deep in-order response pipeline. Stage 0 holds valid/read flags; the
// word read at acceptance arrives registered alongside stage 0 and is carried on.
module dsram_resp_pipe #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load_valid,
  input  logic        load_is_read,
  input  logic [31:0] stage0_word,
  output logic        data_ok,
  output logic [31:0] rdata
);

  logic [LATENCY-1:0] valid_q, valid_d;
  logic [LATENCY-1:0] is_read_q, is_read_d;
  logic [31:0]        last_word;

  always_comb begin
    valid_d      = '0;
    is_read_d    = '0;
    valid_d[0]   = load_valid;
    is_read_d[0] = load_valid & load_is_read;
    for (int i = 1; i < LATENCY; i++) begin
      valid_d[i]   = valid_q[i-1];
      is_read_d[i] = is_read_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q   <= '0;
      is_read_q <= '0;
    end else begin
      valid_q   <= valid_d;
      is_read_q <= is_read_d;
    end
  end

  if (LATENCY == 1) begin : g_direct
    assign last_word = stage0_word;
  end else begin : g_shift
    logic [31:0] word_q [1:LATENCY-1];
    logic [31:0] word_d [1:LATENCY-1];

    // Zero the word for writes so the last stage never carries stale data.
    always_comb begin
      for (int i = 1; i < LATENCY; i++) word_d[i] = '0;
      word_d[1] = is_read_q[0] ? stage0_word : 32'h0;
      for (int i = 2; i < LATENCY; i++) word_d[i] = word_q[i-1];
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        for (int i = 1; i < LATENCY; i++) word_q[i] <= '0;
      end else begin
        for (int i = 1; i < LATENCY; i++) word_q[i] <= word_d[i];
      end
    end

    assign last_word = word_q[LATENCY-1];
  end

  assign data_ok = valid_q[LATENCY-1];
  assign rdata   = (valid_q[LATENCY-1] & is_read_q[LATENCY-1]) ? last_word : 32'h0;

endmodule

// File: rtl/data_sram_responder.sv
// Data-side SRAM-like responder (req/addr_ok/data_ok) over a word-array memory.
// Optional DSRAM_RAND_STALL_EN adds LFSR-driven addr_ok stalls.
module data_sram_responder
  import dsram_pkg::*;
#(
  parameter int MEM_WORDS   = 1024,
  parameter int LATENCY     = 1,
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [CNT_W-1:0] OUT_LIMIT = CNT_W'(OUTSTANDING);

  logic [31:0]      mem_q [MEM_WORDS];
  logic [31:0]      rd_word_q;
  logic [IDX_W-1:0] idx;
  logic             acc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             stall;
  logic             unused_bits;

  assign idx = addr[IDX_W+1:2];
  assign acc = req & addr_ok;

  // Size is informational only; strobes decide which bytes change.
  assign unused_bits = ^{size == SZ_BYTE, size == SZ_HALF, size == SZ_WORD,
                         addr[31:IDX_W+2], addr[1:0]};

  // Memory is never reset; read and write both happen at the accepting edge.
  always_ff @(posedge clk) begin
    if (acc & ~wr) begin
      rd_word_q <= mem_q[idx];
    end
    if (acc & wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    ready_d = 1'b1;
    if (acc && !data_ok) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!acc && data_ok) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // ready_q keeps addr_ok low through reset and releases it one edge later.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

`ifdef DSRAM_RAND_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign addr_ok = ready_q & (cnt_q < OUT_LIMIT) & ~stall;

  dsram_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_resp_pipe (
    .clk          (clk),
    .resetn       (resetn),
    .load_valid   (acc),
    .load_is_read (~wr),
    .stage0_word  (rd_word_q),
    .data_ok      (data_ok),
    .rdata        (rdata)
  );

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder (LATENCY=3, OUTSTANDING=2): a queue-based
// response model checked every cycle plus directed literal expectations.
module tb_data_sram_responder;

  localparam int MW  = 1024;
  localparam int LAT = 3;
  localparam int OUT = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  data_sram_responder #(
    .MEM_WORDS   (MW),
    .LATENCY     (LAT),
    .OUTSTANDING (OUT)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .req     (req),
    .wr      (wr),
    .size    (size),
    .wstrb   (wstrb),
    .addr    (addr),
    .wdata   (wdata),
    .addr_ok (addr_ok),
    .data_ok (data_ok),
    .rdata   (rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired, got no event expected one (cycle %0d)", nm, cyc);
  endtask

  // Behavioural model: word memory plus a queue of responses with due cycles.
  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  resp_t       pend[$];
  logic [31:0] mdl_mem [MW];
  bit          mdl_ready = 0;
  int          acc_log[$];
  int          dok_cyc[$];
  logic [31:0] dok_dat[$];
  int          tot_acc = 0;
  int          tot_dok = 0;

  always @(negedge clk) begin
    bit          exp_dok;
    logic [31:0] exp_rd;
    bit          exp_aok;
    int          wi;
    if (!resetn) begin
      pend.delete();
      mdl_ready = 0;
      tot_acc   = 0;
      tot_dok   = 0;
      chk("reset_addr_ok", {31'b0, addr_ok}, 32'd0);
      chk("reset_data_ok", {31'b0, data_ok}, 32'd0);
      chk("reset_rdata", rdata, 32'd0);
    end else begin
      exp_dok = (pend.size() > 0) && (pend[0].due == cyc);
      exp_rd  = exp_dok ? pend[0].data : 32'd0;
      exp_aok = mdl_ready && (pend.size() < OUT);
`ifdef DSRAM_RAND_STALL_EN
      chk("addr_ok_over_limit", {31'b0, addr_ok & ~exp_aok}, 32'd0);
`else
      chk("addr_ok", {31'b0, addr_ok}, {31'b0, exp_aok});
`endif
      chk("data_ok", {31'b0, data_ok}, {31'b0, exp_dok});
      chk("rdata", rdata, exp_rd);
      if (req && addr_ok) begin
        wi = int'((addr >> 2) % MW);
        acc_log.push_back(cyc);
        tot_acc++;
        if (wr) begin
          for (int b = 0; b < 4; b++)
            if (wstrb[b]) mdl_mem[wi][8*b +: 8] = wdata[8*b +: 8];
          pend.push_back('{due: cyc + LAT, data: 32'd0});
        end else begin
          pend.push_back('{due: cyc + LAT, data: mdl_mem[wi]});
        end
      end
      if (exp_dok) void'(pend.pop_front());
      if (data_ok) begin
        dok_cyc.push_back(cyc);
        dok_dat.push_back(rdata);
        tot_dok++;
      end
      mdl_ready = 1;
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req   = 1'b0;
    wr    = 1'b0;
    wstrb = 4'h0;
  endtask

  task automatic drain(input int n);
    repeat (n) sync();
  endtask

  task automatic clear_logs();
    acc_log.delete();
    dok_cyc.delete();
    dok_dat.delete();
  endtask

  // Holds the request until it is accepted; returns one edge after acceptance.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    bit got;
    req   = 1'b1;
    wr    = w;
    addr  = a;
    wdata = d;
    wstrb = s;
    size  = 2'd2;
    got   = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      got = addr_ok;
      sync();
      if (got) break;
    end
    if (!got) timeout_fail("accept_wait");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    req    = 1'b1;
    wr     = 1'b0;
    size   = 2'd2;
    wstrb  = 4'h0;
    addr   = 32'h100;
    wdata  = 32'h0;

    // Reset with req held high.
    drain(3);
    @(negedge clk);
    chk("rst_hold_addr_ok", {31'b0, addr_ok}, 32'd0);
    chk("rst_hold_data_ok", {31'b0, data_ok}, 32'd0);
    chk("rst_hold_rdata", rdata, 32'd0);
    sync();
    resetn = 1'b1;
    idle();
    sync();
`ifndef DSRAM_RAND_STALL_EN
    @(negedge clk);
    chk("release_addr_ok", {31'b0, addr_ok}, 32'd1);
    sync();
`endif

    // Word write then read next cycle.
    clear_logs();
    issue(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    issue(1'b0, 32'h100, 32'h0, 4'h0);
    idle();
    drain(10);
    chk("wr_rd_n_resp", dok_cyc.size(), 32'd2);
    if (dok_cyc.size() == 2 && acc_log.size() == 2) begin
`ifndef DSRAM_RAND_STALL_EN
      chk("wr_rd_back_to_back", acc_log[1] - acc_log[0], 32'd1);
`endif
      chk("wr_resp_latency", dok_cyc[0] - acc_log[0], 32'd3);
      chk("wr_resp_rdata", dok_dat[0], 32'h0);
      chk("rd_resp_latency", dok_cyc[1] - acc_log[1], 32'd3);
      chk("rd_word", dok_dat[1], 32'hDEADBEEF);
    end

    // Byte strobe, zero strobe, and wrapped address.
    clear_logs();
    issue(1'b1, 32'h102, 32'h00AA0000, 4'b0100);
    issue(1'b0, 32'h100, 32'h0, 4'h0);
    issue(1'b1, 32'h100, 32'hFFFFFFFF, 4'h0);
    issue(1'b0, 32'h100 + 32'(MW * 4), 32'h0, 4'h0);
    idle();
    drain(12);
    chk("strobe_n_resp", dok_cyc.size(), 32'd4);
    if (dok_dat.size() == 4) begin
      chk("byte_strobe_word", dok_dat[1], 32'hDEAABEEF);
      chk("zero_strobe_wrap_word", dok_dat[3], 32'hDEAABEEF);
    end

    // Outstanding limit with req held high.
    clear_logs();
    issue(1'b0, 32'h100, 32'h0, 4'h0);
    issue(1'b0, 32'h104, 32'h0, 4'h0);
    issue(1'b0, 32'h108, 32'h0, 4'h0);
    idle();
    drain(12);
    chk("limit_n_resp", dok_cyc.size(), 32'd3);
`ifndef DSRAM_RAND_STALL_EN
    if (acc_log.size() == 3 && dok_cyc.size() == 3) begin
      chk("limit_acc1", acc_log[1] - acc_log[0], 32'd1);
      chk("limit_acc2", acc_log[2] - acc_log[0], 32'd4);
      chk("limit_dok0", dok_cyc[0] - acc_log[0], 32'd3);
      chk("limit_dok1", dok_cyc[1] - acc_log[0], 32'd4);
      chk("limit_dok2", dok_cyc[2] - acc_log[0], 32'd7);
    end
`endif

    // Reset while a read is in flight.
    clear_logs();
    issue(1'b0, 32'h100, 32'h0, 4'h0);
    idle();
    resetn = 1'b0;
    drain(2);
    resetn = 1'b1;
    sync();
`ifndef DSRAM_RAND_STALL_EN
    @(negedge clk);
    chk("post_reset_addr_ok", {31'b0, addr_ok}, 32'd1);
    sync();
`endif
    drain(8);
    chk("dropped_resp_count", dok_cyc.size(), 32'd0);

    // Random traffic over 16 preinitialised words, checked by the model.
    for (int w = 0; w < 16; w++) issue(1'b1, 32'(w * 4), $urandom, 4'hF);
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = {$urandom_range(0, 7), 20'h0, 4'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 1) issue(1'b1, a, $urandom, 4'($urandom_range(0, 15)));
      else                          issue(1'b0, a, 32'h0, 4'h0);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        sync();
      end
    end
    idle();
    drain(12);
    chk("model_queue_empty", pend.size(), 32'd0);
    chk("accepts_eq_responses", tot_acc, tot_dok);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
